// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment scan driver: active-low glyph table,
// blank pattern and decimal-point bit position.
package seg7_pkg;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam int         DP_BIT    = 7;

  // Segments g..a, active-low, for hex digits 0..F.
  localparam logic [6:0] GLYPH_TAB [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/seg7_glyph.sv
// Combinational hex nibble to active-low seven-segment pattern (g..a).
module seg7_glyph
  import seg7_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [6:0] seg_o
);

  assign seg_o = GLYPH_TAB[nib_i];

endmodule

// File: rtl/seg7_scan.sv
// Time-multiplexed common-anode seven-segment driver with dead-cycle
// anti-ghosting, decimal points, leading-zero suppression and blinking.
module seg7_scan
  import seg7_pkg::*;
#(
  parameter int NDIG      = 4,
  parameter int PRESCALE  = 50000,
  parameter int BLINK_DIV = 64
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [4*NDIG-1:0] DIN,
  input  logic [NDIG-1:0]   DOT,
  input  logic              LOAD,
  input  logic              BLANK_LZ,
  input  logic [NDIG-1:0]   BLINK_EN,
  output logic [7:0]        nSEG,
  output logic [NDIG-1:0]   nDIG,
  output logic              FRAME
);

  localparam int PW = $clog2(PRESCALE);
  localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [PW-1:0]     pre_q, pre_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [BW-1:0]     bcnt_q, bcnt_d;
  logic              phase_q, phase_d;
  logic [4*NDIG-1:0] din_q, din_d;
  logic [NDIG-1:0]   dot_q, dot_d;
  logic [NDIG-1:0]   blink_q, blink_d;
  logic [7:0]        nseg_q, nseg_d;
  logic [NDIG-1:0]   ndig_q, ndig_d;
  logic              frame_q, frame_d;

  logic              slot_end;
  logic              scan_wrap;
  logic [NDIG-1:0]   lz_blank;
  logic              all_zero;
  logic [3:0]        nib_sel;
  logic              dot_sel;
  logic              blink_sel;
  logic              lz_sel;
  logic [6:0]        glyph;

  // Scan counters: prescaler, digit index, and frame-based blink divider.
  always_comb begin
    slot_end  = (pre_q == PW'(PRESCALE - 1));
    scan_wrap = slot_end && (idx_q == IW'(NDIG - 1));
    pre_d     = slot_end ? '0 : pre_q + PW'(1);
    idx_d     = idx_q;
    if (slot_end) idx_d = scan_wrap ? '0 : idx_q + IW'(1);
    frame_d   = scan_wrap;
    bcnt_d    = bcnt_q;
    phase_d   = phase_q;
    if (scan_wrap) begin
      if (bcnt_q == BW'(BLINK_DIV - 1)) begin
        bcnt_d  = '0;
        phase_d = ~phase_q;
      end else begin
        bcnt_d  = bcnt_q + BW'(1);
      end
    end
    din_d   = LOAD ? DIN      : din_q;
    dot_d   = LOAD ? DOT      : dot_q;
    blink_d = LOAD ? BLINK_EN : blink_q;
  end

  // A digit is suppressed when it and every more significant nibble are zero.
  always_comb begin
    lz_blank = '0;
    all_zero = 1'b1;
    for (int i = NDIG - 1; i >= 1; i--) begin
      all_zero    = all_zero & (din_q[4*i +: 4] == 4'h0);
      lz_blank[i] = all_zero & BLANK_LZ;
    end
  end

  always_comb begin
    nib_sel   = '0;
    dot_sel   = 1'b0;
    blink_sel = 1'b0;
    lz_sel    = 1'b0;
    for (int i = 0; i < NDIG; i++) begin
      if (idx_q == IW'(i)) begin
        nib_sel   = din_q[4*i +: 4];
        dot_sel   = dot_q[i];
        blink_sel = blink_q[i];
        lz_sel    = lz_blank[i];
      end
    end
  end

  seg7_glyph u_glyph (
    .nib_i (nib_sel),
    .seg_o (glyph)
  );

  // pre == 0 is the dead cycle that separates consecutive digit slots.
  always_comb begin
    nseg_d = SEG_BLANK;
    ndig_d = '1;
    if (pre_q != '0) begin
      for (int i = 0; i < NDIG; i++) ndig_d[i] = (idx_q != IW'(i));
      if (blink_sel && phase_q) begin
        nseg_d = SEG_BLANK;
      end else if (lz_sel) begin
        nseg_d         = SEG_BLANK;
        nseg_d[DP_BIT] = ~dot_sel;
      end else begin
        nseg_d = {~dot_sel, glyph};
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pre_q   <= '0;
      idx_q   <= '0;
      bcnt_q  <= '0;
      phase_q <= 1'b0;
      din_q   <= '0;
      dot_q   <= '0;
      blink_q <= '0;
      nseg_q  <= SEG_BLANK;
      ndig_q  <= '1;
      frame_q <= 1'b0;
    end else begin
      pre_q   <= pre_d;
      idx_q   <= idx_d;
      bcnt_q  <= bcnt_d;
      phase_q <= phase_d;
      din_q   <= din_d;
      dot_q   <= dot_d;
      blink_q <= blink_d;
      nseg_q  <= nseg_d;
      ndig_q  <= ndig_d;
      frame_q <= frame_d;
    end
  end

  assign nSEG  = nseg_q;
  assign nDIG  = ndig_q;
  assign FRAME = frame_q;

endmodule

// File: tb/tb_seg7_scan.sv
// Directed bench for seg7_scan with NDIG=4, PRESCALE=4, BLINK_DIV=2:
// vector table for glyph/LZ/DP rendering plus hand-written timing sequences.
module tb_seg7_scan;

  logic        CLK = 1'b0;
  logic        RST;
  logic [15:0] DIN;
  logic [3:0]  DOT;
  logic        LOAD;
  logic        BLANK_LZ;
  logic [3:0]  BLINK_EN;
  logic [7:0]  nSEG;
  logic [3:0]  nDIG;
  logic        FRAME;

  int nVec = 0;
  int nMis = 0;

  seg7_scan #(.NDIG(4), .PRESCALE(4), .BLINK_DIV(2)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .DIN      (DIN),
    .DOT      (DOT),
    .LOAD     (LOAD),
    .BLANK_LZ (BLANK_LZ),
    .BLINK_EN (BLINK_EN),
    .nSEG     (nSEG),
    .nDIG     (nDIG),
    .FRAME    (FRAME)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [15:0] din;
    logic [3:0]  dot;
    logic        blz;
    int          dig;
    logic [7:0]  expSeg;
  } vec_t;

  vec_t vecs [32];

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    nVec++;
    if (act !== exp) begin
      nMis++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] din, input logic [3:0] dot,
                               input logic blz, input logic [3:0] blinkEn);
    DIN      = din;
    DOT      = dot;
    BLANK_LZ = blz;
    BLINK_EN = blinkEn;
    LOAD     = 1'b1;
    tick();
    LOAD     = 1'b0;
    tick();
  endtask

  task automatic waitDigit(input int d, input string name);
    logic [3:0] sel;
    bit         found;
    sel   = 4'b0001 << d;
    found = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (nDIG === ~sel) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    if (!found) begin
      nVec++;
      nMis++;
      $display("[TB] FAIL %s: digit %0d never selected, nDIG=%h", name, d, nDIG);
    end
  endtask

  // Release reset with LOAD high so the first edge captures the shadows.
  task automatic releaseReset();
    RST  = 1'b0;
    tick();
    LOAD = 1'b0;
  endtask

  logic [7:0] segTab [4];
  logic [3:0] digTab [4];

  initial begin
    segTab = '{8'h99, 8'hB0, 8'hA4, 8'hF9};
    digTab = '{4'hE, 4'hD, 4'hB, 4'h7};

    vecs[0]  = '{16'h0070, 4'h0, 1'b1, 3, 8'hFF};
    vecs[1]  = '{16'h0070, 4'h0, 1'b1, 2, 8'hFF};
    vecs[2]  = '{16'h0070, 4'h0, 1'b1, 1, 8'hF8};
    vecs[3]  = '{16'h0070, 4'h0, 1'b1, 0, 8'hC0};
    vecs[4]  = '{16'h0000, 4'h0, 1'b1, 3, 8'hFF};
    vecs[5]  = '{16'h0000, 4'h0, 1'b1, 2, 8'hFF};
    vecs[6]  = '{16'h0000, 4'h0, 1'b1, 1, 8'hFF};
    vecs[7]  = '{16'h0000, 4'h0, 1'b1, 0, 8'hC0};
    vecs[8]  = '{16'h0000, 4'h0, 1'b0, 3, 8'hC0};
    vecs[9]  = '{16'h0000, 4'h0, 1'b0, 2, 8'hC0};
    vecs[10] = '{16'h0000, 4'h0, 1'b0, 1, 8'hC0};
    vecs[11] = '{16'h0000, 4'h0, 1'b0, 0, 8'hC0};
    vecs[12] = '{16'h0008, 4'h9, 1'b1, 0, 8'h00};
    vecs[13] = '{16'h0008, 4'h9, 1'b1, 1, 8'hFF};
    vecs[14] = '{16'h0008, 4'h9, 1'b1, 2, 8'hFF};
    vecs[15] = '{16'h0008, 4'h9, 1'b1, 3, 8'h7F};
    vecs[16] = '{16'hFEDC, 4'h0, 1'b0, 0, 8'hC6};
    vecs[17] = '{16'hFEDC, 4'h0, 1'b0, 1, 8'hA1};
    vecs[18] = '{16'hFEDC, 4'h0, 1'b0, 2, 8'h86};
    vecs[19] = '{16'hFEDC, 4'h0, 1'b0, 3, 8'h8E};
    vecs[20] = '{16'h89AB, 4'h0, 1'b0, 0, 8'h83};
    vecs[21] = '{16'h89AB, 4'h0, 1'b0, 1, 8'h88};
    vecs[22] = '{16'h89AB, 4'h0, 1'b0, 2, 8'h90};
    vecs[23] = '{16'h89AB, 4'h0, 1'b0, 3, 8'h80};
    vecs[24] = '{16'h5670, 4'h0, 1'b1, 0, 8'hC0};
    vecs[25] = '{16'h5670, 4'h0, 1'b1, 1, 8'hF8};
    vecs[26] = '{16'h5670, 4'h0, 1'b1, 2, 8'h82};
    vecs[27] = '{16'h5670, 4'h0, 1'b1, 3, 8'h92};
    vecs[28] = '{16'h1002, 4'h0, 1'b1, 3, 8'hF9};
    vecs[29] = '{16'h1002, 4'h0, 1'b1, 2, 8'hC0};
    vecs[30] = '{16'h1002, 4'h0, 1'b1, 1, 8'hC0};
    vecs[31] = '{16'h1002, 4'h0, 1'b1, 0, 8'hA4};

    // Reset held with LOAD active: outputs blank, shadows stay cleared.
    RST      = 1'b1;
    DIN      = 16'h1234;
    DOT      = 4'h0;
    LOAD     = 1'b1;
    BLANK_LZ = 1'b0;
    BLINK_EN = 4'h0;
    tick();
    tick();
    checkOutput("reset nSEG", nSEG, 8'hFF);
    checkOutput("reset nDIG", {4'h0, nDIG}, 8'h0F);
    checkOutput("reset FRAME", {7'h0, FRAME}, 8'h00);

    // Two full frames of scan timing against a cycle-count model.
    releaseReset();
    for (int n = 1; n <= 32; n++) begin
      int s, pre, idx;
      s   = n - 1;
      pre = s % 4;
      idx = (s / 4) % 4;
      checkOutput($sformatf("scan%0d nSEG", n), nSEG, (pre == 0) ? 8'hFF : segTab[idx]);
      checkOutput($sformatf("scan%0d nDIG", n), {4'h0, nDIG}, (pre == 0) ? 8'h0F : {4'h0, digTab[idx]});
      checkOutput($sformatf("scan%0d FRAME", n), {7'h0, FRAME}, (s % 16 == 15) ? 8'h01 : 8'h00);
      tick();
    end

    // Reset asserted mid-slot of digit 2 blanks immediately and restarts at digit 0.
    waitDigit(2, "rstmid");
    tick();
    #2;
    RST = 1'b1;
    #1;
    checkOutput("rstmid nSEG", nSEG, 8'hFF);
    checkOutput("rstmid nDIG", {4'h0, nDIG}, 8'h0F);
    checkOutput("rstmid FRAME", {7'h0, FRAME}, 8'h00);
    tick();
    RST = 1'b0;
    tick();
    checkOutput("restart dead nDIG", {4'h0, nDIG}, 8'h0F);
    tick();
    checkOutput("restart nDIG", {4'h0, nDIG}, 8'h0E);
    checkOutput("restart nSEG", nSEG, 8'hC0);

    // Rendering vectors: glyphs, leading-zero suppression and decimal points.
    for (int v = 0; v < 32; v++) begin
      applyStimulus(vecs[v].din, vecs[v].dot, vecs[v].blz, 4'h0);
      waitDigit(vecs[v].dig, $sformatf("vec%0d", v));
      checkOutput($sformatf("vec%0d din=%h dig%0d", v, vecs[v].din, vecs[v].dig), nSEG, vecs[v].expSeg);
    end

    // Blink: digit 1 visible for two frames, blank for two, others steady.
    RST = 1'b1;
    tick();
    DIN      = 16'h1234;
    DOT      = 4'h0;
    BLANK_LZ = 1'b0;
    BLINK_EN = 4'b0010;
    LOAD     = 1'b1;
    releaseReset();
    for (int f = 0; f < 6; f++) begin
      waitDigit(1, $sformatf("blink%0d", f));
      checkOutput($sformatf("blink frame%0d dig1", f), nSEG, (((f / 2) % 2) == 1) ? 8'hFF : 8'hB0);
      waitDigit(2, $sformatf("blink%0d", f));
      checkOutput($sformatf("blink frame%0d dig2", f), nSEG, 8'hA4);
    end

    // LOAD timing: unloaded DIN change is invisible, a one-cycle LOAD shows next edge.
    RST = 1'b1;
    tick();
    DIN      = 16'h1234;
    BLINK_EN = 4'h0;
    LOAD     = 1'b1;
    releaseReset();
    DIN = 16'h5678;
    tick();
    checkOutput("load e2 nSEG", nSEG, 8'h99);
    checkOutput("load e2 nDIG", {4'h0, nDIG}, 8'h0E);
    LOAD = 1'b1;
    tick();
    LOAD = 1'b0;
    checkOutput("load e3 nSEG", nSEG, 8'h99);
    checkOutput("load e3 nDIG", {4'h0, nDIG}, 8'h0E);
    tick();
    checkOutput("load e4 nSEG", nSEG, 8'h80);
    checkOutput("load e4 nDIG", {4'h0, nDIG}, 8'h0E);
    tick();
    checkOutput("load e5 nSEG", nSEG, 8'hFF);
    checkOutput("load e5 nDIG", {4'h0, nDIG}, 8'h0F);
    tick();
    checkOutput("load e6 nSEG", nSEG, 8'hF8);
    checkOutput("load e6 nDIG", {4'h0, nDIG}, 8'h0D);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

endmodule
